// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// OFF and CNT_W describe the default configuration; modules derive their own from parameters.
package if_pkg;

    typedef enum logic {
        IDLE       = 1'b0,
        DELOT_PEND = 1'b1
    } fetch_state_t;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_FETCH_WIDTH     = 4;
    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int OFF                 = $clog2(DEF_FETCH_WIDTH);
    localparam int CNT_W               = $clog2(DEF_MAX_OUTSTANDING + 1);
    localparam int PC_MAX_W            = 64;

    // Start of the next aligned fetch block; the caller truncates to its own address width.
    function automatic logic [PC_MAX_W-1:0] seq_next_pc(input logic [PC_MAX_W-1:0] pc,
                                                        input int off = OFF);
        logic [PC_MAX_W-1:0] blk;
        blk = (pc >> (off + 2)) + 1'b1;
        return blk << (off + 2);
    endfunction

endpackage

// File: rtl/if_req_tracker.sv
// Counts live icache requests in flight and the responses still owed to flushed fetches.
module if_req_tracker #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = if_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fire,
    input  logic             flush,
    input  logic             rsp_valid,
    output logic [CNT_W-1:0] outstanding,
    output logic             rsp_kill
);

    // Repeated flushes can stack stale responses beyond MAX_OUTSTANDING, so give headroom.
    localparam int KILL_W = CNT_W + 2;

    logic [CNT_W-1:0]  out_q, out_d;
    logic [KILL_W-1:0] kill_q, kill_d;
    logic [KILL_W:0]   kill_sum;
    logic              live_rsp, kill_rsp;

    assign kill_rsp = rsp_valid & (kill_q != '0);
    assign live_rsp = rsp_valid & (kill_q == '0);

    always_comb begin
        out_d    = out_q;
        kill_d   = kill_q;
        kill_sum = {1'b0, kill_q} + {{(KILL_W + 1 - CNT_W){1'b0}}, out_q};
        if (flush) begin
            out_d = '0;
            if (rsp_valid && kill_sum != '0) begin
                kill_sum = kill_sum - 1'b1;
            end
            kill_d = kill_sum[KILL_W] ? '1 : kill_sum[KILL_W-1:0];
        end else begin
            if (fire && !live_rsp) begin
                out_d = out_q + 1'b1;
            end else if (!fire && live_rsp && out_q != '0) begin
                out_d = out_q - 1'b1;
            end
            if (kill_rsp) begin
                kill_d = kill_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            out_q  <= '0;
            kill_q <= '0;
        end else begin
            out_q  <= out_d;
            kill_q <= kill_d;
        end
    end

    assign outstanding = out_q;
    assign rsp_kill    = kill_rsp;

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst_)
        !(rsp_valid && out_q == '0 && kill_q == '0));

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch PC generator: block-aligned sequencing, delay-slot split fetches, and
// mispredict / exception redirects with stale-response tracking.
module if_fetch_ctrl import if_pkg::*; #(
    parameter int                ADDR_W          = DEF_ADDR_W,
    parameter int                FETCH_WIDTH     = DEF_FETCH_WIDTH,
    parameter int                MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter logic [ADDR_W-1:0] RESET_VECTOR    = ADDR_W'(32'hBFC0_0000)
) (
    input  logic                               clk,
    input  logic                               rst_,
    input  logic                               bp_if_en,
    input  logic [ADDR_W-1:0]                  bp_if_target,
    input  logic                               bp_if_delot_en,
    input  logic [ADDR_W-1:0]                  bp_if_delot_pc,
    input  logic                               bp_allin,
    input  logic                               icache_allin,
    input  logic                               icache_rsp_valid,
    input  logic                               ex_bp_error,
    input  logic [ADDR_W-1:0]                  ex_new_target,
    input  logic                               exc_flush_all,
    input  logic [ADDR_W-1:0]                  cp0_if_excaddr,
    output logic [ADDR_W-1:0]                  if_pc,
    output logic                               if_icache_req,
    output logic                               if_icache_delot_en,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]   if_fetch_cnt,
    output logic                               if_rsp_kill,
    output logic                               if_valid_ns
);

    localparam int BLK_OFF = $clog2(FETCH_WIDTH);
    localparam int OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W  = $clog2(FETCH_WIDTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d, saved_target_q, saved_target_d;
    fetch_state_t      state_q, state_d;
    logic              valid_q, delot_q, delot_d;
    logic              flush, req, fire;
    logic [OCNT_W-1:0] outstanding;
    logic [FCNT_W-1:0] blk_cnt;

    assign flush = exc_flush_all | ex_bp_error;
    assign req   = valid_q & ~flush & (outstanding < OCNT_W'(MAX_OUTSTANDING));
    assign fire  = req & icache_allin & bp_allin;

    always_comb begin
        pc_d           = pc_q;
        state_d        = state_q;
        saved_target_d = saved_target_q;
        delot_d        = delot_q;
        if (flush) begin
            pc_d    = exc_flush_all ? cp0_if_excaddr : ex_new_target;
            state_d = IDLE;
            delot_d = 1'b0;
        end else if (fire) begin
            case (state_q)
                DELOT_PEND: begin
                    pc_d    = saved_target_q;
                    delot_d = 1'b0;
                    state_d = IDLE;
                end
                IDLE: begin
                    // A slot outside the block is fetched alone before jumping to the target.
                    if (bp_if_delot_en) begin
                        pc_d           = bp_if_delot_pc;
                        saved_target_d = bp_if_target;
                        delot_d        = 1'b1;
                        state_d        = DELOT_PEND;
                    end else if (bp_if_en) begin
                        pc_d    = bp_if_target;
                        delot_d = 1'b0;
                    end else begin
                        pc_d = ADDR_W'(seq_next_pc(PC_MAX_W'(pc_q), BLK_OFF));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            pc_q           <= RESET_VECTOR;
            valid_q        <= 1'b0;
            state_q        <= IDLE;
            saved_target_q <= '0;
            delot_q        <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            valid_q        <= 1'b1;
            state_q        <= state_d;
            saved_target_q <= saved_target_d;
            delot_q        <= delot_d;
        end
    end

    generate
        if (BLK_OFF == 0) begin : g_single
            assign blk_cnt = FCNT_W'(1);
        end else begin : g_block
            assign blk_cnt = FCNT_W'(FETCH_WIDTH) - FCNT_W'(pc_q[BLK_OFF+1:2]);
        end
    endgenerate

    if_req_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (OCNT_W)
    ) u_req_tracker (
        .clk         (clk),
        .rst_        (rst_),
        .fire        (fire),
        .flush       (flush),
        .rsp_valid   (icache_rsp_valid),
        .outstanding (outstanding),
        .rsp_kill    (if_rsp_kill)
    );

    assign if_pc              = pc_q;
    assign if_icache_req      = req;
    assign if_icache_delot_en = delot_q;
    assign if_fetch_cnt       = delot_q ? FCNT_W'(1) : blk_cnt;
    assign if_valid_ns        = fire;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic against an epoch-tagged request model.
module tb_if_fetch_ctrl;

    localparam int          AW = 32;
    localparam int          FW = 4;
    localparam int          MO = 2;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic          clk, rst_;
    logic          bp_if_en, bp_if_delot_en, bp_allin, icache_allin, icache_rsp_valid;
    logic          ex_bp_error, exc_flush_all;
    logic [AW-1:0] bp_if_target, bp_if_delot_pc, ex_new_target, cp0_if_excaddr;
    logic [AW-1:0] if_pc;
    logic          if_icache_req, if_icache_delot_en, if_rsp_kill, if_valid_ns;
    logic [$clog2(FW+1)-1:0] if_fetch_cnt;

    if_fetch_ctrl #(
        .ADDR_W          (AW),
        .FETCH_WIDTH     (FW),
        .MAX_OUTSTANDING (MO),
        .RESET_VECTOR    (RV)
    ) dut (
        .clk                (clk),
        .rst_               (rst_),
        .bp_if_en           (bp_if_en),
        .bp_if_target       (bp_if_target),
        .bp_if_delot_en     (bp_if_delot_en),
        .bp_if_delot_pc     (bp_if_delot_pc),
        .bp_allin           (bp_allin),
        .icache_allin       (icache_allin),
        .icache_rsp_valid   (icache_rsp_valid),
        .ex_bp_error        (ex_bp_error),
        .ex_new_target      (ex_new_target),
        .exc_flush_all      (exc_flush_all),
        .cp0_if_excaddr     (cp0_if_excaddr),
        .if_pc              (if_pc),
        .if_icache_req      (if_icache_req),
        .if_icache_delot_en (if_icache_delot_en),
        .if_fetch_cnt       (if_fetch_cnt),
        .if_rsp_kill        (if_rsp_kill),
        .if_valid_ns        (if_valid_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each in-flight request is tagged with the redirect epoch it was issued in.
    logic [31:0] m_pc, m_saved;
    bit          m_valid, m_slot;
    int          m_epoch;
    int          q[$];
    int          errors, checks;
    bit          rsp_en;
    logic        last_kill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_live();
        int n = 0;
        foreach (q[i]) if (q[i] == m_epoch) n++;
        return n;
    endfunction

    function automatic bit m_req();
        return m_valid && !(exc_flush_all || ex_bp_error) && (m_live() < MO);
    endfunction

    function automatic bit m_fire();
        return m_req() && icache_allin && bp_allin;
    endfunction

    function automatic int m_cnt();
        return m_slot ? 1 : FW - ((m_pc >> 2) % FW);
    endfunction

    function automatic bit m_kill();
        return icache_rsp_valid && (q.size() > 0) && (q[0] != m_epoch);
    endfunction

    task automatic model_reset();
        m_pc = RV; m_saved = 0; m_valid = 0; m_slot = 0; m_epoch = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit f;
        f = m_fire();
        if (icache_rsp_valid && q.size() > 0) void'(q.pop_front());
        if (exc_flush_all || ex_bp_error) begin
            m_pc   = exc_flush_all ? cp0_if_excaddr : ex_new_target;
            m_slot = 0;
            m_epoch++;
        end else if (f) begin
            q.push_back(m_epoch);
            if (m_slot) begin
                m_pc   = m_saved;
                m_slot = 0;
            end else if (bp_if_delot_en) begin
                m_saved = bp_if_target;
                m_pc    = bp_if_delot_pc;
                m_slot  = 1;
            end else if (bp_if_en) begin
                m_pc = bp_if_target;
            end else begin
                m_pc = (m_pc - (m_pc % (FW * 4))) + FW * 4;
            end
        end
        m_valid = 1;
    endtask

    task automatic cycle();
        icache_rsp_valid = rsp_en && (q.size() > 0);
        @(negedge clk);
        last_kill = if_rsp_kill;
        chk("pc",    if_pc,                     m_pc);
        chk("req",   32'(if_icache_req),        32'(m_req()));
        chk("delot", 32'(if_icache_delot_en),   32'(m_slot));
        chk("cnt",   32'(if_fetch_cnt),         32'(m_cnt()));
        chk("kill",  32'(if_rsp_kill),          32'(m_kill()));
        chk("fire",  32'(if_valid_ns),          32'(m_fire()));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        bp_if_en = 0; bp_if_delot_en = 0; bp_allin = 1; icache_allin = 1;
        ex_bp_error = 0; exc_flush_all = 0; rsp_en = 1;
    endtask

    task automatic do_reset();
        icache_rsp_valid = 0;
        rst_ = 1;
        #1;
        chk("rst_pc",    if_pc,                   RV);
        chk("rst_req",   32'(if_icache_req),      0);
        chk("rst_delot", 32'(if_icache_delot_en), 0);
        chk("rst_kill",  32'(if_rsp_kill),        0);
        chk("rst_fire",  32'(if_valid_ns),        0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 0;
    endtask

    initial begin
        errors = 0; checks = 0;
        bp_if_target = 0; bp_if_delot_pc = 0; ex_new_target = 0; cp0_if_excaddr = 0;
        icache_rsp_valid = 0;
        set_idle();
        rst_ = 1;
        model_reset();
        #2;
        chk("rst_cnt", 32'(if_fetch_cnt), FW);
        do_reset();

        // Sequential fetch from the reset vector.
        cycle(); chk("seq0", if_pc, RV);
        cycle(); chk("seq1", if_pc, 32'hBFC0_0010); chk("seq1_cnt", 32'(if_fetch_cnt), 4);
        cycle(); chk("seq2", if_pc, 32'hBFC0_0020);

        // Misaligned mispredict redirect.
        ex_bp_error = 1; ex_new_target = 32'h8000_0008;
        cycle(); ex_bp_error = 0;
        chk("redir_pc", if_pc, 32'h8000_0008); chk("redir_cnt", 32'(if_fetch_cnt), 2);
        cycle(); chk("redir_seq", if_pc, 32'h8000_0010);

        // Delay slot outside the block, target 0.
        bp_if_en = 1; bp_if_delot_en = 1; bp_if_delot_pc = 32'h1010; bp_if_target = 32'h0;
        cycle(); bp_if_en = 0; bp_if_delot_en = 0;
        chk("slot_pc", if_pc, 32'h1010); chk("slot_delot", 32'(if_icache_delot_en), 1);
        chk("slot_cnt", 32'(if_fetch_cnt), 1);
        cycle(); chk("slot_tgt", if_pc, 32'h0); chk("slot_done", 32'(if_icache_delot_en), 0);

        // Stall inside DELOT_PEND.
        bp_if_en = 1; bp_if_delot_en = 1; bp_if_delot_pc = 32'h2000; bp_if_target = 32'h3000;
        cycle(); bp_if_en = 0; bp_if_delot_en = 0; bp_if_target = 32'h7777_0000;
        icache_allin = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", if_pc, 32'h2000);
            chk("stall_fire", 32'(if_valid_ns), 0);
        end
        icache_allin = 1;
        cycle(); chk("stall_resume", if_pc, 32'h3000);

        // Outstanding limit, then exception flush kills the stale responses.
        rsp_en = 0;
        repeat (4) cycle();
        chk("limit_req", 32'(if_icache_req), 0);
        exc_flush_all = 1; cp0_if_excaddr = 32'hBFC0_0380;
        cycle(); exc_flush_all = 0;
        chk("exc_pc", if_pc, 32'hBFC0_0380);
        rsp_en = 1;
        cycle(); chk("kill1", 32'(last_kill), 1);
        cycle(); chk("kill2", 32'(last_kill), 1);
        cycle(); chk("kill3", 32'(last_kill), 0);

        // Both flush sources together; exception wins.
        exc_flush_all = 1; ex_bp_error = 1;
        cp0_if_excaddr = 32'hBFC0_0180; ex_new_target = 32'h1234_5678;
        cycle(); exc_flush_all = 0; ex_bp_error = 0;
        chk("both_pc", if_pc, 32'hBFC0_0180);

        // Reset while a delay-slot target is pending.
        bp_if_delot_en = 1; bp_if_delot_pc = 32'h4000; bp_if_target = 32'h5000;
        cycle(); bp_if_delot_en = 0;
        chk("pend_delot", 32'(if_icache_delot_en), 1);
        do_reset();
        cycle(); cycle();
        chk("post_rst_seq", if_pc, 32'hBFC0_0010);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bp_if_en       = ($urandom % 4) == 0;
            bp_if_delot_en = ($urandom % 8) == 0;
            bp_if_target   = $urandom & ~32'h3;
            bp_if_delot_pc = $urandom & ~32'h3;
            bp_allin       = ($urandom % 5) != 0;
            icache_allin   = ($urandom % 5) != 0;
            ex_bp_error    = ($urandom % 16) == 0;
            exc_flush_all  = ($urandom % 24) == 0;
            ex_new_target  = $urandom & ~32'h3;
            cp0_if_excaddr = $urandom & ~32'h3;
            rsp_en         = ($urandom % 3) != 0;
            if (($urandom % 500) == 0) do_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Parametrised instruction-fetch PC generator and request controller for the front end. It issues one aligned fetch block of FETCH_WIDTH words per handshake to the icache and BP. It handles branch-delay-slot sequencing with an explicit state machine, and applies EX mispredict and CP0 exception redirects. It also tracks outstanding icache requests so that responses belonging to flushed fetches are marked for discard.

Parameters:
ADDR_W, 32, PC/address width in bits.
FETCH_WIDTH, 4, words per fetch block; power of 2, range 1..8.
MAX_OUTSTANDING, 2, maximum icache requests in flight; range 1..7.
RESET_VECTOR, 32'hBFC0_0000, first fetch PC after reset.

Ports:
clk  in  1  system clock
rst_  in  1  reset, asynchronous, active-high
bp_if_en  in  1  BP predicts a taken branch in the current block
bp_if_target  in  ADDR_W  predicted target
bp_if_delot_en  in  1  predicted branch has its delay slot outside the current block
bp_if_delot_pc  in  ADDR_W  delay-slot PC
bp_allin  in  1  BP can accept a fetch
icache_allin  in  1  icache can accept a request
icache_rsp_valid  in  1  icache returns one fetch block
ex_bp_error  in  1  EX mispredict redirect
ex_new_target  in  ADDR_W  corrected PC
exc_flush_all  in  1  CP0 exception flush
cp0_if_excaddr  in  ADDR_W  exception vector
if_pc  out  ADDR_W  current fetch PC, shared by icache and BP
if_icache_req  out  1  request valid
if_icache_delot_en  out  1  current request is a lone delay-slot fetch
if_fetch_cnt  out  $clog2(FETCH_WIDTH+1)  valid words in the current block
if_rsp_kill  out  1  current icache response must be dropped
if_valid_ns  out  1  fetch accepted this cycle (fire)

Behaviour:
- Definitions:
  - OFF = log2(FETCH_WIDTH).
  - flush = exc_flush_all | ex_bp_error.
  - if_icache_req = if_valid & !flush & (outstanding < MAX_OUTSTANDING).
  - fire = if_icache_req & icache_allin & bp_allin.
  - if_valid_ns = fire.
- Reset while rst_ is high:
  - if_pc = RESET_VECTOR; if_valid = 0; state = IDLE.
  - saved_target = 0; outstanding = 0; kill_cnt = 0; if_icache_delot_en = 0.
  - All outputs are 0 except if_pc and if_fetch_cnt.
- if_valid rises on the first clk edge after reset release. The first request can therefore fire in cycle 1.
- Fetch count:
  - if_fetch_cnt = FETCH_WIDTH − if_pc[OFF+1:2]; this is 1 for FETCH_WIDTH=1.
  - When if_icache_delot_en=1, if_fetch_cnt = 1.
- Sequential next PC: {if_pc[ADDR_W-1:OFF+2] + 1, zeros}. It wraps modulo 2^ADDR_W.
- State machine, IDLE / DELOT_PEND, evaluated only on fire:
  - IDLE & bp_if_delot_en: next pc = bp_if_delot_pc; saved_target = bp_if_target; if_icache_delot_en = 1; go to DELOT_PEND.
  - IDLE & bp_if_en: next pc = bp_if_target; delot_en = 0.
  - IDLE, otherwise: sequential next PC.
  - DELOT_PEND: next pc = saved_target; delot_en = 0; go to IDLE. BP inputs are ignored in this state.
  - No fire: pc, state and saved_target hold. A target of 0 is legal.
- Flush has priority over everything except reset, and does not depend on the allin signals:
  - If exc_flush_all: if_pc = cp0_if_excaddr. Else if ex_bp_error: if_pc = ex_new_target. exc_flush_all wins when both are asserted.
  - state = IDLE; delot_en = 0; if_valid = 1.
  - kill_cnt = kill_cnt + outstanding − icache_rsp_valid.
  - outstanding = 0.
  - No request is issued in a flush cycle.
- Response tracking:
  - outstanding changes by +fire − (icache_rsp_valid & kill_cnt==0).
  - if_rsp_kill = icache_rsp_valid & (kill_cnt != 0); each killed response decrements kill_cnt.
  - icache_rsp_valid with nothing pending is a protocol violation. Counters saturate at 0 and a simulation assertion fires.
- Simultaneous events:
  - fire together with a live response in the same cycle: outstanding is unchanged.
  - flush arriving while in DELOT_PEND: the pending target is discarded.

Decomposition:
- Package if_pkg holds:
  - fetch_state_t enum {IDLE, DELOT_PEND};
  - localparams OFF and CNT_W = $clog2(MAX_OUTSTANDING+1);
  - a function seq_next_pc().
- Sub-module if_req_tracker (outstanding/kill counters, if_rsp_kill) is instantiated once.

Test Plan:
- Reset release, allins=1, FETCH_WIDTH=4, bp idle, rsp returns 1 cycle after each fire:
  - expected PCs 0xBFC00000, 0xBFC00010, 0xBFC00020;
  - if_fetch_cnt=4 each cycle.
- Misaligned redirect: ex_bp_error with ex_new_target=0x8000_0008 -> next if_pc=0x8000_0008, cnt=2; following PC 0x8000_0010.
- Delay slot:
  - stimulus in IDLE: bp_if_delot_en=1, delot_pc=0x1010, target=0x0 on fire;
  - expected: pc=0x1010 with delot_en=1 and cnt=1, then pc=0x0 with state IDLE.
- Stall: icache_allin=0 for 3 cycles in DELOT_PEND -> pc, state and saved_target hold; if_valid_ns=0.
- Outstanding limit and kill:
  - MAX_OUTSTANDING=2 with no responses -> req drops after 2 fires;
  - exc_flush_all -> pc=cp0_if_excaddr;
  - the next 2 responses assert if_rsp_kill; the 3rd response does not.
- Simultaneous exc_flush_all and ex_bp_error -> cp0_if_excaddr is taken; rst_ asserted mid-DELOT_PEND returns every register to its reset value immediately.
